// File: rtl/sha2_pkg.sv
// Shared types and default widths for the SHA-2 message padder.
package sha2_pkg;

  localparam int unsigned BLOCK_W_DEFAULT = 512;
  localparam int unsigned LEN_W_DEFAULT   = 64;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StPad,
    StDrain
  } state_e;

  // Reserved scheme encodings collapse onto SchemeBypass once latched.
  typedef enum logic {
    SchemePad,
    SchemeBypass
  } scheme_e;

endpackage

// File: rtl/sha2_msg_padder_if.sv
// Message-in, config and padded-block-out streams of the SHA-2 padder.
interface sha2_msg_padder_if import sha2_pkg::*; #(
  parameter int unsigned BLOCK_W = BLOCK_W_DEFAULT,
  parameter int unsigned LEN_W   = LEN_W_DEFAULT
) ();

  logic [BLOCK_W-1:0] data_in;
  logic               data_in_valid;
  logic               data_in_ready;
  logic               data_in_last;

  logic [LEN_W-1:0]   cfg_size;
  logic [1:0]         cfg_scheme;
  logic               cfg_valid;
  logic               cfg_ready;

  logic [BLOCK_W-1:0] data_out;
  logic               data_out_valid;
  logic               data_out_ready;
  logic               data_out_last;

  logic               len_err;

  modport master (
    output data_in, data_in_valid, data_in_last,
    output cfg_size, cfg_scheme, cfg_valid,
    output data_out_ready,
    input  data_in_ready, cfg_ready,
    input  data_out, data_out_valid, data_out_last, len_err
  );

  modport slave (
    input  data_in, data_in_valid, data_in_last,
    input  cfg_size, cfg_scheme, cfg_valid,
    input  data_out_ready,
    output data_in_ready, cfg_ready,
    output data_out, data_out_valid, data_out_last, len_err
  );

endinterface

// File: rtl/msg_pad_insert.sv
// Combinational pad inserter: keep the top rem bits, optionally set the
// 1-bit right after them, optionally OR the length into the low bits.
module msg_pad_insert #(
  parameter int unsigned BLOCK_W = 512,
  parameter int unsigned LEN_W   = 64
) (
  input  logic [BLOCK_W-1:0]         block,
  input  logic [$clog2(BLOCK_W)-1:0] rem,
  input  logic                       pad_en,
  input  logic                       len_en,
  input  logic [LEN_W-1:0]           len,
  output logic [BLOCK_W-1:0]         padded
);

  localparam logic [BLOCK_W-1:0] Ones = '1;
  localparam logic [BLOCK_W-1:0] Msb  = {1'b1, {(BLOCK_W-1){1'b0}}};

  // Mask message bits, then overlay pad bit and length field.
  always_comb begin
    padded = block & ~(Ones >> rem);
    if (pad_en) begin
      padded = padded | (Msb >> rem);
    end
    if (len_en) begin
      padded[LEN_W-1:0] = padded[LEN_W-1:0] | len;
    end
  end

endmodule

// File: rtl/sha2_msg_padder.sv
// SHA-2 message padder: appends the 1-bit, zero fill and bit length to a
// block stream, with a bypass scheme and length-mismatch recovery.
module sha2_msg_padder import sha2_pkg::*; #(
  parameter int unsigned BLOCK_W = BLOCK_W_DEFAULT,
  parameter int unsigned LEN_W   = LEN_W_DEFAULT
) (
  input logic              clk,
  input logic              nrst,
  sha2_msg_padder_if.slave bus
);

  localparam int unsigned REM_W   = $clog2(BLOCK_W);
  localparam int unsigned CNT_W   = LEN_W - REM_W + 1;
  localparam int unsigned FIT_MAX = BLOCK_W - LEN_W - 1;

  state_e             state_q, state_d;
  scheme_e            scheme_q, scheme_d;
  logic [LEN_W-1:0]   size_q, size_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, exp_q, exp_d, cnt_inc;
  logic               pad_bit_q, pad_bit_d, drain_q, drain_d, init_q;
  logic [BLOCK_W-1:0] dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d, dout_last_q, dout_last_d;
  logic               len_err_q, len_err_d;

  logic               slot_free, in_ready, in_fire, cfg_fire, count_hit, len_fits;
  logic [REM_W-1:0]   rem, cfg_rem, ins_rem;
  logic [BLOCK_W-1:0] ins_block, ins_out;
  logic               ins_pad, ins_len_en;

  assign slot_free = !dout_valid_q || bus.data_out_ready;
  assign in_ready  = (state_q == StData && slot_free) || state_q == StDrain;
  assign in_fire   = bus.data_in_valid && in_ready;
  assign cfg_fire  = bus.cfg_valid && bus.cfg_ready;
  assign rem       = size_q[REM_W-1:0];
  assign cfg_rem   = bus.cfg_size[REM_W-1:0];
  assign cnt_inc   = cnt_q + 1'b1;
  assign count_hit = (cnt_inc == exp_q);
  assign len_fits  = (rem <= REM_W'(FIT_MAX));

  assign bus.cfg_ready      = (state_q == StIdle) && init_q;
  assign bus.data_in_ready  = in_ready;
  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = dout_valid_q;
  assign bus.data_out_last  = dout_last_q;
  assign bus.len_err        = len_err_q;

  // PAD emits a fresh block built from zeros; DATA pads the incoming beat.
  always_comb begin
    ins_block  = bus.data_in;
    ins_rem    = rem;
    ins_pad    = 1'b1;
    ins_len_en = len_fits;
    if (state_q == StPad) begin
      ins_block  = '0;
      ins_rem    = '0;
      ins_pad    = pad_bit_q;
      ins_len_en = 1'b1;
    end
  end

  msg_pad_insert #(
    .BLOCK_W(BLOCK_W),
    .LEN_W  (LEN_W)
  ) u_insert (
    .block (ins_block),
    .rem   (ins_rem),
    .pad_en(ins_pad),
    .len_en(ins_len_en),
    .len   (size_q),
    .padded(ins_out)
  );

  // Next-state and output-register load logic.
  always_comb begin
    state_d      = state_q;
    scheme_d     = scheme_q;
    size_d       = size_q;
    cnt_d        = cnt_q;
    exp_d        = exp_q;
    pad_bit_d    = pad_bit_q;
    drain_d      = drain_q;
    dout_d       = dout_q;
    dout_last_d  = dout_last_q;
    dout_valid_d = dout_valid_q && !bus.data_out_ready;
    len_err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_fire) begin
          size_d    = bus.cfg_size;
          scheme_d  = (bus.cfg_scheme == 2'b00) ? SchemePad : SchemeBypass;
          len_err_d = bus.cfg_scheme[1];
          cnt_d     = '0;
          // Zero-length messages still consume exactly one beat.
          exp_d     = {1'b0, bus.cfg_size[LEN_W-1:REM_W]}
                    + CNT_W'(cfg_rem != '0 || bus.cfg_size == '0);
          pad_bit_d = 1'b0;
          drain_d   = 1'b0;
          state_d   = StData;
        end
      end
      StData: begin
        if (in_fire) begin
          dout_valid_d = 1'b1;
          if (scheme_q == SchemeBypass) begin
            dout_d      = bus.data_in;
            dout_last_d = bus.data_in_last;
            if (bus.data_in_last) state_d = StIdle;
          end else if (!count_hit && !bus.data_in_last) begin
            dout_d      = bus.data_in;
            dout_last_d = 1'b0;
            cnt_d       = cnt_inc;
          end else begin
            len_err_d = count_hit ^ bus.data_in_last;
            drain_d   = !bus.data_in_last;
            if (size_q != '0 && rem == '0) begin
              // Full final block: the 1-bit goes at the top of the PAD block.
              dout_d      = bus.data_in;
              dout_last_d = 1'b0;
              pad_bit_d   = 1'b1;
              state_d     = StPad;
            end else if (len_fits) begin
              dout_d      = ins_out;
              dout_last_d = 1'b1;
              state_d     = bus.data_in_last ? StIdle : StDrain;
            end else begin
              dout_d      = ins_out;
              dout_last_d = 1'b0;
              pad_bit_d   = 1'b0;
              state_d     = StPad;
            end
          end
        end
      end
      StPad: begin
        if (slot_free) begin
          dout_d       = ins_out;
          dout_valid_d = 1'b1;
          dout_last_d  = 1'b1;
          state_d      = drain_q ? StDrain : StIdle;
        end
      end
      StDrain: begin
        if (in_fire && bus.data_in_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; init_q holds cfg_ready low until the first edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= StIdle;
      scheme_q     <= SchemePad;
      size_q       <= '0;
      cnt_q        <= '0;
      exp_q        <= '0;
      pad_bit_q    <= 1'b0;
      drain_q      <= 1'b0;
      init_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      scheme_q     <= scheme_d;
      size_q       <= size_d;
      cnt_q        <= cnt_d;
      exp_q        <= exp_d;
      pad_bit_q    <= pad_bit_d;
      drain_q      <= drain_d;
      init_q       <= 1'b1;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      len_err_q    <= len_err_d;
    end
  end

endmodule

// File: tb/tb_sha2_msg_padder.sv
// Directed, table-driven bench for sha2_msg_padder at 512/64.
module tb_sha2_msg_padder;

  localparam int BW = 512;
  localparam int LW = 64;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  sha2_msg_padder_if #(.BLOCK_W(BW), .LEN_W(LW)) bus ();

  sha2_msg_padder #(.BLOCK_W(BW), .LEN_W(LW)) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  typedef struct packed {
    logic [63:0]         size;
    logic [1:0]          scheme;
    logic [1:0]          nbeats;
    logic [1:0]          in_last;
    logic [1:0][BW-1:0]  beats;
    logic [1:0]          nexp;
    logic [2:0]          exp_last;
    logic [2:0][BW-1:0]  exp_blk;
    logic                exp_err;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;
  int err_total = 0;
  logic [BW-1:0] oq [$];
  logic          ol [$];

  // Record every accepted output block and every len_err cycle.
  always @(negedge clk) begin
    if (nrst && bus.data_out_valid && bus.data_out_ready) begin
      oq.push_back(bus.data_out);
      ol.push_back(bus.data_out_last);
    end
    if (bus.len_err) err_total <= err_total + 1;
  end

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [63:0] size, input logic [1:0] scheme,
                         input logic [1:0] nbeats, input logic [1:0] in_last,
                         input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                         input logic [1:0] nexp, input logic [2:0] exp_last,
                         input logic [BW-1:0] e0, input logic [BW-1:0] e1,
                         input logic [BW-1:0] e2, input logic exp_err);
    vecs[i].size     = size;
    vecs[i].scheme   = scheme;
    vecs[i].nbeats   = nbeats;
    vecs[i].in_last  = in_last;
    vecs[i].beats[0] = b0;
    vecs[i].beats[1] = b1;
    vecs[i].nexp     = nexp;
    vecs[i].exp_last = exp_last;
    vecs[i].exp_blk[0] = e0;
    vecs[i].exp_blk[1] = e1;
    vecs[i].exp_blk[2] = e2;
    vecs[i].exp_err  = exp_err;
  endtask

  task automatic send_cfg(input logic [63:0] size, input logic [1:0] scheme);
    logic hs = 1'b0;
    int n = 0;
    bus.cfg_size   = size;
    bus.cfg_scheme = scheme;
    bus.cfg_valid  = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = bus.cfg_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.cfg_valid = 1'b0;
    chk("cfg handshake", BW'(hs), BW'(1));
  endtask

  task automatic send_beat(input logic [BW-1:0] data, input logic last);
    logic hs = 1'b0;
    int n = 0;
    bus.data_in       = data;
    bus.data_in_last  = last;
    bus.data_in_valid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = bus.data_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.data_in_valid = 1'b0;
    bus.data_in_last  = 1'b0;
    chk("beat handshake", BW'(hs), BW'(1));
  endtask

  task automatic check_outputs(input int i, input string tag, input int e0);
    int n = 0;
    while (oq.size() < int'(vecs[i].nexp) && n < 60) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk($sformatf("%s block count", tag), BW'(oq.size()), BW'(vecs[i].nexp));
    for (int k = 0; k < int'(vecs[i].nexp); k++) begin
      if (k < oq.size()) begin
        chk($sformatf("%s blk%0d data", tag, k), oq[k], vecs[i].exp_blk[k]);
        chk($sformatf("%s blk%0d last", tag, k), BW'(ol[k]), BW'(vecs[i].exp_last[k]));
      end
    end
    chk($sformatf("%s len_err pulses", tag), BW'(err_total - e0), BW'(vecs[i].exp_err));
    chk($sformatf("%s back to idle", tag), BW'(bus.cfg_ready), BW'(1));
  endtask

  task automatic run_vec(input int i);
    int e0;
    oq.delete();
    ol.delete();
    e0 = err_total;
    send_cfg(vecs[i].size, vecs[i].scheme);
    for (int b = 0; b < int'(vecs[i].nbeats); b++) begin
      send_beat(vecs[i].beats[b], vecs[i].in_last[b]);
    end
    check_outputs(i, $sformatf("v%0d", i), e0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " data_out"}, bus.data_out, '0);
    chk({tag, " data_out_valid"}, BW'(bus.data_out_valid), '0);
    chk({tag, " data_out_last"}, BW'(bus.data_out_last), '0);
    chk({tag, " len_err"}, BW'(bus.len_err), '0);
    chk({tag, " cfg_ready"}, BW'(bus.cfg_ready), '0);
    chk({tag, " data_in_ready"}, BW'(bus.data_in_ready), '0);
  endtask

  initial begin
    int e0;
    logic [BW-1:0] abc, abc_junk, abc_exp, ff, z;
    z        = '0;
    ff       = '1;
    abc      = {24'h616263, 488'h0};
    abc_junk = {24'h616263, {61{8'hFF}}};
    abc_exp  = {32'h61626380, 416'h0, 64'h18};

    //       idx size   sch nb  last  beat0             beat1          nexp lastv blk0 / blk1 / blk2 err
    set_vec(0, 24,   2'b00, 1, 2'b01, abc, z, 1, 3'b001, abc_exp, z, z, 1'b0);
    set_vec(1, 448,  2'b00, 1, 2'b01, {64{8'hA5}}, z, 2, 3'b010,
            {{56{8'hA5}}, 64'h8000_0000_0000_0000}, {448'h0, 64'h1C0}, z, 1'b0);
    set_vec(2, 1024, 2'b00, 2, 2'b10, {64{8'h11}}, {64{8'h22}}, 3, 3'b100,
            {64{8'h11}}, {64{8'h22}}, {8'h80, 440'h0, 64'h400}, 1'b0);
    set_vec(3, 0,    2'b00, 1, 2'b01, ff, z, 1, 3'b001, {8'h80, 504'h0}, z, z, 1'b0);
    set_vec(4, 5,    2'b01, 2, 2'b10, {64{8'h3C}}, {64{8'hC3}}, 2, 3'b010,
            {64{8'h3C}}, {64{8'hC3}}, z, 1'b0);
    set_vec(5, 24,   2'b10, 1, 2'b01, {64{8'h77}}, z, 1, 3'b001, {64{8'h77}}, z, z, 1'b1);
    set_vec(6, 24,   2'b00, 2, 2'b10, abc_junk, ff, 1, 3'b001, abc_exp, z, z, 1'b1);
    set_vec(7, 600,  2'b00, 1, 2'b01, {64{8'h5A}}, z, 1, 3'b001,
            {{11{8'h5A}}, 8'h80, 352'h0, 64'h258}, z, z, 1'b1);

    bus.data_in        = '0;
    bus.data_in_valid  = 1'b0;
    bus.data_in_last   = 1'b0;
    bus.cfg_size       = '0;
    bus.cfg_scheme     = 2'b00;
    bus.cfg_valid      = 1'b0;
    bus.data_out_ready = 1'b1;

    // Reset values, and cfg_ready staying low until the first edge after release.
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    nrst = 1'b1;
    #1;
    chk("cfg_ready before first edge", BW'(bus.cfg_ready), '0);
    @(posedge clk);
    #1;
    chk("cfg_ready after first edge", BW'(bus.cfg_ready), BW'(1));

    for (int i = 0; i < NVEC; i++) begin
      run_vec(i);
    end

    // Output back-pressure for five cycles in the middle of a 1024-bit message.
    oq.delete();
    ol.delete();
    e0 = err_total;
    send_cfg(vecs[2].size, vecs[2].scheme);
    fork
      begin
        send_beat(vecs[2].beats[0], 1'b0);
        send_beat(vecs[2].beats[1], 1'b1);
      end
      begin
        int n = 0;
        while (!bus.data_out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        #1;
        bus.data_out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          #1;
          chk("stall valid held", BW'(bus.data_out_valid), BW'(1));
          chk("stall data held", bus.data_out, vecs[2].exp_blk[oq.size()]);
          chk("stall last held", BW'(bus.data_out_last), BW'(vecs[2].exp_last[oq.size()]));
        end
        @(posedge clk);
        #1;
        bus.data_out_ready = 1'b1;
      end
    join
    check_outputs(2, "stall", e0);

    // Asynchronous reset with a message half-way through.
    oq.delete();
    ol.delete();
    send_cfg(1024, 2'b00);
    send_beat({64{8'h11}}, 1'b0);
    bus.data_out_ready = 1'b0;
    @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    @(negedge clk);
    nrst = 1'b1;
    bus.data_out_ready = 1'b1;
    #1;
    chk("mid reset cfg_ready low", BW'(bus.cfg_ready), '0);
    @(posedge clk);
    #1;
    chk("mid reset cfg_ready high", BW'(bus.cfg_ready), BW'(1));
    chk("mid reset no output", BW'(bus.data_out_valid), '0);
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit in case a handshake loop misbehaves.
  initial begin
    #200000;
    $display("FAIL global timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
